zap_wb_merger_n: RTL and testbench

Parametrised N-master Wishbone B3 arbiter/merger that sits between the code/data caches (and any added bus masters, e.g. a DMA or table walker) and the store-buffer adapter. It generalises the fixed two-master code/data merger to NUM_MASTERS requesters and adds selectable fixed-priority or round-robin arbitration. Grant is burst-aware: it is held for the whole `cyc` tenure of the winning master. Requests are taken in `_nxt` form and re-registered onto the shared bus.

---
 rtl/zap_wb_merger_n.sv | 135 +++++++++++++
 tb/tb_zap_wb_merger_n.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_wb_merger_n.sv
// N-master Wishbone B3 merger: registers the winning master's _nxt request onto the
// shared bus and holds the grant for the whole cyc tenure (fixed priority or round-robin).
module zap_wb_merger_n #(
    parameter int NUM_MASTERS = 2,
    parameter int ARB_MODE    = 0
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic [NUM_MASTERS-1:0]            i_m_wb_cyc,
    input  logic [NUM_MASTERS-1:0]            i_m_wb_stb,
    input  logic [NUM_MASTERS-1:0]            i_m_wb_wen,
    input  logic [4*NUM_MASTERS-1:0]          i_m_wb_sel,
    input  logic [32*NUM_MASTERS-1:0]         i_m_wb_dat,
    input  logic [32*NUM_MASTERS-1:0]         i_m_wb_adr,
    input  logic [3*NUM_MASTERS-1:0]          i_m_wb_cti,
    output logic [NUM_MASTERS-1:0]            o_m_wb_ack,
    output logic                              o_wb_cyc,
    output logic                              o_wb_stb,
    output logic                              o_wb_wen,
    output logic [3:0]                        o_wb_sel,
    output logic [31:0]                       o_wb_dat,
    output logic [31:0]                       o_wb_adr,
    output logic [2:0]                        o_wb_cti,
    input  logic                              i_wb_ack,
    output logic [$clog2(NUM_MASTERS)-1:0]    o_gnt
);

    localparam int GW = $clog2(NUM_MASTERS);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        wen;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] adr;
        logic [2:0]  cti;
    } bus_t;

    state_t                   state, state_nxt;
    logic [GW-1:0]            gnt, gnt_nxt;
    logic [GW-1:0]            rr_ptr, rr_ptr_nxt;
    logic [GW-1:0]            base, winner, sel_idx;
    logic [2*NUM_MASTERS-1:0] req_dbl;
    logic [NUM_MASTERS-1:0]   req_rot;
    logic                     found;
    bus_t                     bus, bus_nxt, pick;

    // Rotate requests so the search starts at bit 0; fixed priority is a rotation of zero.
    always_comb begin
        base    = (ARB_MODE == 1) ? rr_ptr : '0;
        req_dbl = {i_m_wb_cyc, i_m_wb_cyc} >> base;
        req_rot = req_dbl[NUM_MASTERS-1:0];
        winner  = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req_rot[i]) begin
                found  = 1'b1;
                winner = GW'((int'(base) + i) % NUM_MASTERS);
            end
        end
    end

    always_comb begin
        sel_idx = (state == IDLE) ? winner : gnt;
        pick    = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (sel_idx == GW'(k)) begin
                pick = {i_m_wb_cyc[k], i_m_wb_stb[k], i_m_wb_wen[k],
                        i_m_wb_sel[4*k +: 4], i_m_wb_dat[32*k +: 32],
                        i_m_wb_adr[32*k +: 32], i_m_wb_cti[3*k +: 3]};
            end
        end
    end

    // In BUSY, pick is the owner's request, so pick.cyc is the owner still holding cyc.
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        rr_ptr_nxt = rr_ptr;
        bus_nxt    = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                    gnt_nxt   = winner;
                    bus_nxt   = pick;
                end
            end
            BUSY: begin
                if (pick.cyc) begin
                    bus_nxt = pick;
                end else begin
                    state_nxt = IDLE;
                    if (ARB_MODE == 1) begin
                        rr_ptr_nxt = (gnt == GW'(NUM_MASTERS-1)) ? '0 : gnt + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
            bus    <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            rr_ptr <= rr_ptr_nxt;
            bus    <= bus_nxt;
        end
    end

    always_comb begin
        o_m_wb_ack = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            o_m_wb_ack[k] = i_wb_ack && (state == BUSY) && (gnt == GW'(k));
        end
    end

    assign o_wb_cyc = bus.cyc;
    assign o_wb_stb = bus.stb;
    assign o_wb_wen = bus.wen;
    assign o_wb_sel = bus.sel;
    assign o_wb_dat = bus.dat;
    assign o_wb_adr = bus.adr;
    assign o_wb_cti = bus.cti;
    assign o_gnt    = gnt;

endmodule

// File: tb/tb_zap_wb_merger_n.sv
// Bench for zap_wb_merger_n: a fixed-priority and a round-robin instance share all
// inputs and are compared against directed expectations and a behavioural model.
module tb_zap_wb_merger_n;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        wen;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] adr;
        logic [2:0]  cti;
    } bus_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [3:0]   m_cyc = '0, m_stb = '0, m_wen = '0;
    logic [15:0]  m_sel = '0;
    logic [127:0] m_dat = '0, m_adr = '0;
    logic [11:0]  m_cti = '0;
    logic         ack = 1'b0;

    logic [3:0]   ack0, ack1;
    logic [1:0]   gnt0, gnt1;
    logic         o0_cyc, o0_stb, o0_wen, o1_cyc, o1_stb, o1_wen;
    logic [3:0]   o0_sel, o1_sel;
    logic [31:0]  o0_dat, o0_adr, o1_dat, o1_adr;
    logic [2:0]   o0_cti, o1_cti;
    bus_t         obs0, obs1;

    int total = 0;
    int bad = 0;

    // Behavioural model per arbitration mode: owner flag, last grant, round-robin start.
    int   mb[2], mg[2], mr[2];
    bus_t eb[2];

    always #5 clk = ~clk;

    zap_wb_merger_n #(.NUM_MASTERS(4), .ARB_MODE(0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m_wb_cyc(m_cyc), .i_m_wb_stb(m_stb), .i_m_wb_wen(m_wen), .i_m_wb_sel(m_sel),
        .i_m_wb_dat(m_dat), .i_m_wb_adr(m_adr), .i_m_wb_cti(m_cti), .o_m_wb_ack(ack0),
        .o_wb_cyc(o0_cyc), .o_wb_stb(o0_stb), .o_wb_wen(o0_wen), .o_wb_sel(o0_sel),
        .o_wb_dat(o0_dat), .o_wb_adr(o0_adr), .o_wb_cti(o0_cti), .i_wb_ack(ack), .o_gnt(gnt0)
    );

    zap_wb_merger_n #(.NUM_MASTERS(4), .ARB_MODE(1)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m_wb_cyc(m_cyc), .i_m_wb_stb(m_stb), .i_m_wb_wen(m_wen), .i_m_wb_sel(m_sel),
        .i_m_wb_dat(m_dat), .i_m_wb_adr(m_adr), .i_m_wb_cti(m_cti), .o_m_wb_ack(ack1),
        .o_wb_cyc(o1_cyc), .o_wb_stb(o1_stb), .o_wb_wen(o1_wen), .o_wb_sel(o1_sel),
        .o_wb_dat(o1_dat), .o_wb_adr(o1_adr), .o_wb_cti(o1_cti), .i_wb_ack(ack), .o_gnt(gnt1)
    );

    assign obs0 = {o0_cyc, o0_stb, o0_wen, o0_sel, o0_dat, o0_adr, o0_cti};
    assign obs1 = {o1_cyc, o1_stb, o1_wen, o1_sel, o1_dat, o1_adr, o1_cti};

    function automatic bus_t fields(int k);
        return {m_cyc[k], m_stb[k], m_wen[k], m_sel[4*k +: 4], m_dat[32*k +: 32],
                m_adr[32*k +: 32], m_cti[3*k +: 3]};
    endfunction

    function automatic logic [3:0] exp_ack(int md);
        return (mb[md] != 0 && ack) ? 4'(1 << mg[md]) : 4'b0000;
    endfunction

    // One clock edge: advance the model from the inputs the DUTs sample, then settle.
    task automatic tick();
        int w, k;
        @(posedge clk);
        for (int md = 0; md < 2; md++) begin
            if (mb[md] == 0) begin
                w = -1;
                for (int i = 0; i < 4; i++) begin
                    k = (md == 1) ? (mr[md] + i) % 4 : i;
                    if (w < 0 && m_cyc[k]) w = k;
                end
                if (w >= 0) begin
                    mb[md] = 1;
                    mg[md] = w;
                    eb[md] = fields(w);
                end else begin
                    eb[md] = '0;
                end
            end else if (m_cyc[mg[md]]) begin
                eb[md] = fields(mg[md]);
            end else begin
                eb[md] = '0;
                mb[md] = 0;
                if (md == 1) mr[md] = (mg[md] + 1) % 4;
            end
        end
        #1;
    endtask

    task automatic assert_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int md = 0; md < 2; md++) begin
            mb[md] = 0; mg[md] = 0; mr[md] = 0; eb[md] = '0;
        end
    endtask

    task automatic release_reset();
        m_cyc = '0;
        ack   = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic idle_bus();
        m_cyc = '0;
        ack   = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        ack = 1'b1;
        assert_reset();
        total++; if (obs0 !== '0 || obs1 !== '0) begin bad++; $display("[TB] FAIL reset_bus obs=%h/%h exp=0", obs0, obs1); end
        total++; if (gnt0 !== 2'd0 || gnt1 !== 2'd0) begin bad++; $display("[TB] FAIL reset_gnt obs=%0d/%0d exp=0", gnt0, gnt1); end
        total++; if (ack0 !== 4'b0 || ack1 !== 4'b0) begin bad++; $display("[TB] FAIL reset_ack obs=%b/%b exp=0000", ack0, ack1); end
        release_reset();
    endtask

    task automatic test_single_master();
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_adr[64 +: 32] = 32'h1000;
        tick();
        total++; if (o0_cyc !== 1'b1 || o0_adr !== 32'h1000) begin bad++; $display("[TB] FAIL single_bus obs=%b/%h exp=1/00001000", o0_cyc, o0_adr); end
        total++; if (gnt0 !== 2'd2) begin bad++; $display("[TB] FAIL single_gnt obs=%0d exp=2", gnt0); end
        ack = 1'b1;
        #1;
        total++; if (ack0 !== 4'b0100) begin bad++; $display("[TB] FAIL single_ack obs=%b exp=0100", ack0); end
        tick();
        tick();
        m_cyc[2] = 1'b0;
        ack = 1'b0;
        #1;
        total++; if (ack0 !== 4'b0000) begin bad++; $display("[TB] FAIL single_ack_low obs=%b exp=0000", ack0); end
        tick();
        total++; if (o0_cyc !== 1'b0) begin bad++; $display("[TB] FAIL single_release obs=%b exp=0", o0_cyc); end
        idle_bus();
    endtask

    task automatic test_fixed_priority();
        m_cyc = 4'b1010; m_stb = 4'b1010;
        m_adr[32 +: 32] = 32'h2000; m_adr[96 +: 32] = 32'h3000;
        tick();
        total++; if (gnt0 !== 2'd1 || o0_adr !== 32'h2000) begin bad++; $display("[TB] FAIL prio_first obs=%0d/%h exp=1/00002000", gnt0, o0_adr); end
        tick();
        m_cyc[1] = 1'b0;
        tick();
        ack = 1'b1;
        #1;
        total++; if (o0_cyc !== 1'b0 || ack0 !== 4'b0000) begin bad++; $display("[TB] FAIL prio_gap obs=%b/%b exp=0/0000", o0_cyc, ack0); end
        tick();
        total++; if (gnt0 !== 2'd3 || o0_cyc !== 1'b1 || o0_adr !== 32'h3000) begin bad++; $display("[TB] FAIL prio_second obs=%0d/%b/%h exp=3/1/00003000", gnt0, o0_cyc, o0_adr); end
        total++; if (ack0 !== 4'b1000) begin bad++; $display("[TB] FAIL prio_ack obs=%b exp=1000", ack0); end
        idle_bus();
    endtask

    task automatic test_round_robin();
        int e;
        assert_reset();
        release_reset();
        for (int r = 0; r < 5; r++) begin
            e = r % 4;
            m_cyc = 4'hF;
            ack = 1'b1;
            tick();
            total++; if (gnt1 !== 2'(e) || o1_cyc !== 1'b1) begin bad++; $display("[TB] FAIL rr_gnt round=%0d obs=%0d/%b exp=%0d/1", r, gnt1, o1_cyc, e); end
            total++; if (ack1 !== 4'(1 << e)) begin bad++; $display("[TB] FAIL rr_ack round=%0d obs=%b exp=%b", r, ack1, 4'(1 << e)); end
            tick();
            m_cyc[e] = 1'b0;
            tick();
            total++; if (o1_cyc !== 1'b0) begin bad++; $display("[TB] FAIL rr_idle round=%0d obs=%b exp=0", r, o1_cyc); end
        end
        idle_bus();
    endtask

    task automatic test_burst_lock();
        logic [2:0] cti;
        assert_reset();
        release_reset();
        m_cyc = 4'b0011; m_stb = 4'b0011;
        ack = 1'b1;
        for (int b = 0; b < 8; b++) begin
            cti = (b == 7) ? 3'b111 : 3'b010;
            m_adr[0 +: 32] = 32'h4000 + 32'(4 * b);
            m_cti[0 +: 3] = cti;
            tick();
            total++; if (gnt0 !== 2'd0 || gnt1 !== 2'd0 || o0_adr !== 32'h4000 + 32'(4 * b) || o0_cti !== cti)
                begin bad++; $display("[TB] FAIL burst_beat b=%0d obs=%0d/%0d/%h/%b exp=0/0/%h/%b", b, gnt0, gnt1, o0_adr, o0_cti, 32'h4000 + 32'(4 * b), cti); end
            total++; if (ack0 !== 4'b0001 || ack1 !== 4'b0001) begin bad++; $display("[TB] FAIL burst_ack b=%0d obs=%b/%b exp=0001", b, ack0, ack1); end
        end
        m_cyc[0] = 1'b0;
        tick();
        total++; if (o0_cyc !== 1'b0 || o1_cyc !== 1'b0) begin bad++; $display("[TB] FAIL burst_release obs=%b/%b exp=0", o0_cyc, o1_cyc); end
        tick();
        total++; if (gnt0 !== 2'd1 || gnt1 !== 2'd1) begin bad++; $display("[TB] FAIL burst_next obs=%0d/%0d exp=1", gnt0, gnt1); end
        idle_bus();
    endtask

    task automatic test_reset_mid_burst();
        m_cyc = 4'b0010; m_stb = 4'b0010; m_cti[3 +: 3] = 3'b010;
        tick();
        tick();
        ack = 1'b1;
        assert_reset();
        total++; if (obs0 !== '0 || obs1 !== '0) begin bad++; $display("[TB] FAIL midrst_bus obs=%h/%h exp=0", obs0, obs1); end
        total++; if (ack0 !== 4'b0 || ack1 !== 4'b0 || gnt0 !== 2'd0 || gnt1 !== 2'd0) begin bad++; $display("[TB] FAIL midrst_ctl obs=%b/%b/%0d/%0d exp=0", ack0, ack1, gnt0, gnt1); end
        release_reset();
        m_cyc = 4'b0111;
        tick();
        total++; if (gnt0 !== 2'd0 || gnt1 !== 2'd0 || o0_cyc !== 1'b1 || o1_cyc !== 1'b1) begin bad++; $display("[TB] FAIL midrst_first obs=%0d/%0d exp=0/0", gnt0, gnt1); end
        idle_bus();
    endtask

    task automatic test_spurious_ack();
        ack = 1'b1;
        tick();
        total++; if (ack0 !== 4'b0 || ack1 !== 4'b0) begin bad++; $display("[TB] FAIL spurious_ack obs=%b/%b exp=0000", ack0, ack1); end
        ack = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (m_cyc[k]) m_cyc[k] = ($urandom_range(3) != 0);
                else          m_cyc[k] = ($urandom_range(2) == 0);
            end
            m_stb = 4'($urandom); m_wen = 4'($urandom); m_sel = 16'($urandom);
            m_dat = {$urandom, $urandom, $urandom, $urandom};
            m_adr = {$urandom, $urandom, $urandom, $urandom};
            m_cti = 12'($urandom);
            ack   = 1'($urandom);
            #1;
            total++; if (ack0 !== exp_ack(0) || ack1 !== exp_ack(1)) begin bad++; $display("[TB] FAIL rand_ack c=%0d obs=%b/%b exp=%b/%b", c, ack0, ack1, exp_ack(0), exp_ack(1)); end
            tick();
            total++; if (obs0 !== eb[0]) begin bad++; $display("[TB] FAIL rand_bus0 c=%0d obs=%h exp=%h", c, obs0, eb[0]); end
            total++; if (obs1 !== eb[1]) begin bad++; $display("[TB] FAIL rand_bus1 c=%0d obs=%h exp=%h", c, obs1, eb[1]); end
            total++; if (gnt0 !== 2'(mg[0]) || gnt1 !== 2'(mg[1])) begin bad++; $display("[TB] FAIL rand_gnt c=%0d obs=%0d/%0d exp=%0d/%0d", c, gnt0, gnt1, mg[0], mg[1]); end
        end
        idle_bus();
    endtask

    initial begin
        for (int md = 0; md < 2; md++) begin
            mb[md] = 0; mg[md] = 0; mr[md] = 0; eb[md] = '0;
        end
        #1;
        test_reset();
        test_spurious_ack();
        test_single_master();
        test_fixed_priority();
        test_round_robin();
        test_burst_lock();
        test_reset_mid_burst();
        test_random();
        test_spurious_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
